// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants and state encoding for the pipeline stage register
package pipe_pkg;
    localparam logic [31:0] NOP_INSTR   = 32'b0;
    localparam logic [31:0] PC_RST_DFLT = 32'h3008;
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;
endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: instr/pc8/data holding register with load and clear-to-bubble (clear wins)
module pipe_slot import pipe_pkg::*; #(
    parameter int          DATA_W = 64,
    parameter logic [31:0] PC_RST = PC_RST_DFLT
) (
    input  logic              clk,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [31:0]       instr_i,
    input  logic [31:0]       pc8_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [31:0]       instr_o,
    output logic [31:0]       pc8_o,
    output logic [DATA_W-1:0] data_o
);
    logic [31:0]       instr_q, instr_d, pc8_q, pc8_d;
    logic [DATA_W-1:0] data_q, data_d;
    always_comb begin
        instr_d = clear_i ? NOP_INSTR : load_i ? instr_i : instr_q;
        pc8_d   = clear_i ? PC_RST    : load_i ? pc8_i   : pc8_q;
        data_d  = clear_i ? '0        : load_i ? data_i  : data_q;
    end
    always_ff @(posedge clk) begin
        instr_q <= instr_d;
        pc8_q   <= pc8_d;
        data_q  <= data_d;
    end
    assign instr_o = instr_q;
    assign pc8_o   = pc8_q;
    assign data_o  = data_q;
endmodule

// File: rtl/pipe_stage.sv
// pipe_stage: valid/ready pipeline register with 2-entry skid; PIPE_STAGE_STAT_EN builds stall/bubble counters
module pipe_stage import pipe_pkg::*; #(
    parameter int          DATA_W = 64,
    parameter logic [31:0] PC_RST = PC_RST_DFLT,
    parameter int          CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [31:0]       in_pc8,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [31:0]       out_pc8,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stat_stall,
    output logic [CNT_W-1:0]  stat_bubble
);
    state_e            state_q, state_d;
    logic              acc, rel, kill, main_load, main_clr, skid_load, skid_clr, main_from_skid;
    logic [31:0]       skid_instr, skid_pc8, main_instr_d, main_pc8_d;
    logic [DATA_W-1:0] skid_data, main_data_d;
    assign in_ready  = state_q != FULL;
    assign out_valid = state_q != EMPTY;
    always_comb begin
        acc            = in_valid && in_ready;
        rel            = out_valid && out_ready;
        kill           = reset || flush;
        main_from_skid = state_q == FULL;
        main_load      = (state_q == EMPTY && acc) || (state_q == ONE && acc && rel) || (state_q == FULL && rel);
        main_clr       = kill || (state_q == ONE && rel && !acc);
        skid_load      = state_q == ONE && acc && !rel;
        skid_clr       = kill || (state_q == FULL && rel);
        main_instr_d   = main_from_skid ? skid_instr : in_instr;
        main_pc8_d     = main_from_skid ? skid_pc8   : in_pc8;
        main_data_d    = main_from_skid ? skid_data  : in_data;
        state_d        = kill ? EMPTY :
                         state_q == EMPTY ? (acc ? ONE : EMPTY) :
                         state_q == ONE   ? ((acc && !rel) ? FULL : (rel && !acc) ? EMPTY : ONE) :
                         (rel ? ONE : FULL);
    end
    always_ff @(posedge clk) begin
        if (reset) state_q <= EMPTY;
        else       state_q <= state_d;
    end
    pipe_slot #(.DATA_W(DATA_W), .PC_RST(PC_RST)) u_main (
        .clk(clk), .load_i(main_load), .clear_i(main_clr),
        .instr_i(main_instr_d), .pc8_i(main_pc8_d), .data_i(main_data_d),
        .instr_o(out_instr), .pc8_o(out_pc8), .data_o(out_data)
    );
    pipe_slot #(.DATA_W(DATA_W), .PC_RST(PC_RST)) u_skid (
        .clk(clk), .load_i(skid_load), .clear_i(skid_clr),
        .instr_i(in_instr), .pc8_i(in_pc8), .data_i(in_data),
        .instr_o(skid_instr), .pc8_o(skid_pc8), .data_o(skid_data)
    );
`ifdef PIPE_STAGE_STAT_EN
    logic [CNT_W-1:0] stall_q, stall_d, bubble_q, bubble_d;
    always_comb begin
        stall_d  = stall_q  + CNT_W'(out_valid && !out_ready && !(&stall_q));
        bubble_d = bubble_q + CNT_W'(!out_valid && !(&bubble_q));
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
        end
    end
    assign stat_stall  = stall_q;
    assign stat_bubble = bubble_q;
`else
    assign stat_stall  = '0;
    assign stat_bubble = '0;
`endif
endmodule

// File: tb/tb_pipe_stage.sv
// tb_pipe_stage: randomized checks of pipe_stage against a queue-based model of the stage
module tb_pipe_stage;
    localparam int          DATA_W = 64;
    localparam int          CNT_W  = 32;
    localparam logic [31:0] PC_RST = 32'h3008;
`ifdef PIPE_STAGE_STAT_EN
    localparam int STAT = 1;
`else
    localparam int STAT = 0;
`endif
    typedef struct packed {
        logic [31:0]       instr;
        logic [31:0]       pc8;
        logic [DATA_W-1:0] data;
    } ent_t;
    logic              clk = 0, reset = 1, flush = 0, in_valid = 0, out_ready = 0;
    logic              in_ready, out_valid;
    logic [31:0]       in_instr = 0, in_pc8 = 0, out_instr, out_pc8;
    logic [DATA_W-1:0] in_data = 0, out_data;
    logic [CNT_W-1:0]  stat_stall, stat_bubble;
    ent_t              mq[$];
    logic [CNT_W-1:0]  m_stall = 0, m_bubble = 0;
    int                total = 0, passed = 0;
    pipe_stage #(.DATA_W(DATA_W), .PC_RST(PC_RST), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc8(in_pc8), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc8(out_pc8), .out_data(out_data),
        .stat_stall(stat_stall), .stat_bubble(stat_bubble)
    );
    always #5 clk = ~clk;
    task automatic step();
        logic acc, rel;
        @(posedge clk);
        if (reset) begin
            mq.delete();
            m_stall  = '0;
            m_bubble = '0;
        end else begin
            if (mq.size() != 0 && !out_ready && m_stall != '1) m_stall++;
            if (mq.size() == 0 && m_bubble != '1) m_bubble++;
            acc = in_valid && mq.size() < 2;
            rel = mq.size() != 0 && out_ready;
            if (flush) mq.delete();
            else begin
                if (rel) void'(mq.pop_front());
                if (acc) mq.push_back('{in_instr, in_pc8, in_data});
            end
        end
        #1;
    endtask
    task automatic drive(input logic v);
        in_valid = v;
        in_instr = $urandom;
        in_pc8   = $urandom;
        in_data  = {$urandom, $urandom};
    endtask
    function automatic logic [193:0] exp_vec();
        ent_t h;
        h = mq.size() != 0 ? mq[0] : '{32'b0, PC_RST, {DATA_W{1'b0}}};
        return {mq.size() < 2, mq.size() != 0, h, STAT != 0 ? m_stall : '0, STAT != 0 ? m_bubble : '0};
    endfunction
    function automatic logic [193:0] obs();
        return {in_ready, out_valid, out_instr, out_pc8, out_data, stat_stall, stat_bubble};
    endfunction
    task automatic test_reset();
        reset = 1;
        drive(0);
        repeat (2) step();
        total++;
        if (obs() !== {1'b1, 1'b0, 32'b0, 32'h3008, 64'b0, 32'b0, 32'b0})
            $display("FAIL reset got %h exp %h", obs(), {1'b1, 1'b0, 32'b0, 32'h3008, 64'b0, 32'b0, 32'b0});
        else passed++;
        reset = 0;
        step();
        total++;
        if (obs() !== exp_vec()) $display("FAIL reset_release got %h exp %h", obs(), exp_vec());
        else passed++;
    endtask
    task automatic test_stream();
        out_ready = 1;
        for (int k = 0; k < 8; k++) begin
            drive(1);
            in_pc8 = 32'h3008 + 32'(4 * k);
            step();
            total++;
            if (obs() !== exp_vec() || out_pc8 !== 32'h3008 + 32'(4 * k))
                $display("FAIL stream[%0d] got %h exp %h", k, obs(), exp_vec());
            else passed++;
        end
        drive(0);
        step();
        total++;
        if (obs() !== exp_vec()) $display("FAIL stream_tail got %h exp %h", obs(), exp_vec());
        else passed++;
    endtask
    task automatic test_backpressure();
        out_ready = 0;
        for (int k = 0; k < 3; k++) begin
            drive(1);
            step();
            total++;
            if (obs() !== exp_vec() || in_ready !== (k == 0))
                $display("FAIL backpressure_fill[%0d] got %h exp %h", k, obs(), exp_vec());
            else passed++;
        end
        drive(0);
        out_ready = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            total++;
            if (obs() !== exp_vec()) $display("FAIL backpressure_drain[%0d] got %h exp %h", k, obs(), exp_vec());
            else passed++;
        end
    endtask
    task automatic test_flush();
        out_ready = 0;
        repeat (2) begin
            drive(1);
            step();
        end
        flush = 1;
        drive(1);
        step();
        flush = 0;
        total++;
        if (obs() !== exp_vec() || out_valid !== 1'b0 || out_pc8 !== PC_RST || in_ready !== 1'b1)
            $display("FAIL flush got %h exp %h", obs(), exp_vec());
        else passed++;
        drive(0);
        out_ready = 1;
        for (int k = 0; k < 2; k++) begin
            step();
            total++;
            if (obs() !== exp_vec()) $display("FAIL flush_after[%0d] got %h exp %h", k, obs(), exp_vec());
            else passed++;
        end
    endtask
    task automatic test_back_to_back();
        out_ready = 1;
        drive(1);
        step();
        for (int k = 0; k < 5; k++) begin
            drive(1);
            step();
            total++;
            if (obs() !== exp_vec() || in_ready !== 1'b1 || out_valid !== 1'b1)
                $display("FAIL back_to_back[%0d] got %h exp %h", k, obs(), exp_vec());
            else passed++;
        end
        drive(0);
        step();
    endtask
    task automatic test_stats();
        logic [CNT_W-1:0] s0, b0;
        out_ready = 0;
        drive(1);
        step();
        drive(0);
        s0 = stat_stall;
        repeat (10) step();
        total++;
        if (obs() !== exp_vec() || stat_stall - s0 !== CNT_W'(STAT * 10))
            $display("FAIL stat_stall got %0d exp %0d", stat_stall - s0, STAT * 10);
        else passed++;
        out_ready = 1;
        step();
        b0 = stat_bubble;
        repeat (4) step();
        total++;
        if (obs() !== exp_vec() || stat_bubble - b0 !== CNT_W'(STAT * 4))
            $display("FAIL stat_bubble got %0d exp %0d", stat_bubble - b0, STAT * 4);
        else passed++;
        flush = 1;
        step();
        flush = 0;
        total++;
        if (obs() !== exp_vec() || stat_stall - s0 !== CNT_W'(STAT * 10))
            $display("FAIL stat_flush got %h exp %h", obs(), exp_vec());
        else passed++;
    endtask
    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(3, 0) != 0);
            out_ready = $urandom_range(2, 0) != 0;
            flush     = $urandom_range(19, 0) == 0;
            reset     = k == 300;
            step();
            total++;
            if (obs() !== exp_vec()) $display("FAIL random[%0d] got %h exp %h", k, obs(), exp_vec());
            else passed++;
        end
        reset = 0;
        flush = 0;
    endtask
    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_back_to_back();
        test_stats();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
